// File: rtl/bloco_operativo.sv
// Datapath for the polynomial-evaluation controller: three working registers
// (RX, RH, RS), a shared combinational ALU with a constant-coefficient source,
// and a sticky overflow flag. Every register load happens in one cycle.
module bloco_operativo #(
  parameter int            W  = 8,
  parameter logic [W-1:0]  C1 = 8'd3,
  parameter logic [W-1:0]  C2 = 8'd5,
  parameter logic [W-1:0]  C3 = 8'd2
) (
  input  logic         clk,
  input  logic         RST,
  input  logic [W-1:0] X_in,
  input  logic         LX,
  input  logic         LH,
  input  logic         LS,
  input  logic         H,
  input  logic [1:0]   M0,
  input  logic [1:0]   M1,
  input  logic [1:0]   M2,
  output logic [W-1:0] S,
  output logic         Z,
  output logic         OVF
);

  logic [W-1:0]   rx_q, rx_d;
  logic [W-1:0]   rh_q, rh_d;
  logic [W-1:0]   rs_q, rs_d;
  logic           ovf_q, ovf_d;

  logic [W-1:0]   coef;
  logic [W-1:0]   a_op;
  logic [W-1:0]   b_op;
  logic [W:0]     sum;
  logic [2*W-1:0] prod;
  logic [W-1:0]   alu_r;
  logic           alu_ovf;

  // Operand selection: coefficient ROM, operand A mux, operand B mux.
  always_comb begin
    coef = '0;
    case (M0)
      2'b00:   coef = '0;
      2'b01:   coef = C1;
      2'b10:   coef = C2;
      2'b11:   coef = C3;
      default: coef = '0;
    endcase

    a_op = '0;
    case (M1)
      2'b00:   a_op = rh_q;
      2'b01:   a_op = rx_q;
      2'b10:   a_op = rs_q;
      2'b11:   a_op = '0;
      default: a_op = '0;
    endcase

    b_op = H ? coef : rx_q;
  end

  // ALU: result is the low W bits of the full-precision operation, with the
  // overflow condition derived from the bits that were dropped.
  always_comb begin
    sum     = {1'b0, a_op} + {1'b0, b_op};
    prod    = {{W{1'b0}}, a_op} * {{W{1'b0}}, b_op};
    alu_r   = '0;
    alu_ovf = 1'b0;
    case (M2)
      2'b00: begin
        alu_r   = sum[W-1:0];
        alu_ovf = sum[W];
      end
      2'b01: begin
        alu_r   = a_op - b_op;
        alu_ovf = (a_op < b_op);
      end
      2'b10: begin
        alu_r   = prod[W-1:0];
        alu_ovf = |prod[2*W-1:W];
      end
      2'b11: begin
        alu_r   = b_op;
        alu_ovf = 1'b0;
      end
      default: begin
        alu_r   = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  // Next-state: independent loads; OVF set by an overflowing load beats the
  // clear that LX applies at the start of a new computation.
  always_comb begin
    rx_d  = LX ? X_in  : rx_q;
    rh_d  = LH ? alu_r : rh_q;
    rs_d  = LS ? alu_r : rs_q;
    ovf_d = ovf_q;
    if ((LH || LS) && alu_ovf) begin
      ovf_d = 1'b1;
    end else if (LX) begin
      ovf_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      rx_q  <= '0;
      rh_q  <= '0;
      rs_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      rx_q  <= rx_d;
      rh_q  <= rh_d;
      rs_q  <= rs_d;
      ovf_q <= ovf_d;
    end
  end

  assign S   = rs_q;
  assign Z   = (rs_q == '0);
  assign OVF = ovf_q;

endmodule

// File: doc/bloco_operativo.md
# bloco_operativo

Datapath companion to the FSM controller: it executes the load-enable and mux-select words the controller issues each cycle. It holds three working registers (RX, RH, RS), a shared ALU with a constant-coefficient source and a sticky overflow flag. The controller sequences a polynomial-style evaluation through these signals, and the result is presented on S when the controller raises `finished`.

## Interface
- W, 8, datapath width in bits
- C1, 8'd3, coefficient constant selected by M0=01
- C2, 8'd5, coefficient constant selected by M0=10
- C3, 8'd2, coefficient constant selected by M0=11

- clk  in  1  clock; all state changes on rising edge
- RST  in  1  asynchronous, active-low reset
- X_in  in  W  operand sampled into RX when LX=1
- LX  in  1  load RX from X_in
- LH  in  1  load RH from ALU result
- LS  in  1  load RS from ALU result
- H  in  1  ALU operand-B select: 1 = coefficient (per M0), 0 = RX
- M0  in  2  coefficient select: 00 = 0, 01 = C1, 10 = C2, 11 = C3
- M1  in  2  ALU operand-A select: 00 = RH, 01 = RX, 10 = RS, 11 = 0
- M2  in  2  ALU op: 00 = A+B, 01 = A−B, 10 = A·B, 11 = pass B
- S  out  W  result, driven directly from RS
- Z  out  1  1 when RS == 0 (combinational from RS)
- OVF  out  1  sticky arithmetic overflow flag

## Operation
- Reset (RST=0, asynchronous): RX=RH=RS=0, OVF=0, so S=0 and Z=1. Registers hold at 0 while RST=0, regardless of load signals.
- ALU is purely combinational from the current register values and selects. The result R is the low W bits of the full-precision operation.
- Overflow condition, evaluated per cycle:
  - add: carry out of bit W−1
  - sub: borrow (A < B)
  - mul: any nonzero bit in product[2W−1:W]
  - pass: never overflows
- Register loads at the rising edge:
  - LX=1: RX ← X_in.
  - LH=1: RH ← R.
  - LS=1: RS ← R.
  - Loads are independent; any combination may be asserted in the same cycle.
- Simultaneous LX with LH or LS: R uses the old RX value, because the new X_in is not visible until the next cycle.
- LH and LS together: both registers receive the same R.
- OVF:
  - Set at the edge of any cycle with (LH or LS) = 1 and the overflow condition true.
  - Cleared at the edge of any cycle with LX=1, which marks the start of a new computation.
  - If LX and an overflowing load occur together, the set wins and OVF=1.
- No load asserted: all registers hold. Select values are don't-care in that cycle.
- Undefined/X selects while no load is asserted must not corrupt any register.

## Timing
- Single clock domain with no internal pipeline. A load issued in cycle n is visible on S/Z/OVF after edge n, i.e. in cycle n+1.
- Control inputs are treated as registered controller outputs, valid for the whole cycle. The ALU path must close in one cycle, including the W×W multiply.
- Reference controller sequence (one line per cycle), producing RS = (C1+C2)·X:
  - LX: load X.
  - LH with M2=11, H=1, M0=01: RH=C1.
  - LH with M2=00, M1=00, M0=10: RH=C1+C2.
  - LS with M2=11, H=0: RS=X.
  - LS with M2=10, M1=00, H=0: RS=RH·X.
  - Repeated LS cycle: idempotent, RS unchanged.
- S remains stable after LS deasserts until the next LS or reset.
- Reset mid-sequence: outputs return to reset values immediately, without waiting for clk. The first rising edge after RST goes high obeys the inputs.

## Test plan
- Reset: hold RST=0 with LX=LH=LS=1 toggling for 3 cycles → S=0, Z=1, OVF=0 throughout; release → first LX with X_in=7 gives RX=7 one cycle later.
- Full controller sequence, X_in=4, default constants → RH=3 then 8, RS=4 then 32; final S=32, Z=0, OVF=0, S stable for 5 idle cycles.
- Multiply overflow: same sequence with X_in=100 → RS=800 mod 256 = 32, OVF=1; next LX with X_in=1 → OVF=0.
- Subtract borrow: RH=3, RX=5, M1=00, H=0, M2=01, LS=1 → RS=254, OVF=1, Z=0; then M2=01 with A=B=5 (M1=01, H=0) → RS=0, Z=1, OVF stays 1.
- Simultaneous events: LX=1 (X_in=9) with LH=1, M2=11, H=0 while RX=4 → RH=4 (old RX), RX=9. LH=LS=1 with pass C3 → RH=RS=2.
- Asynchronous reset mid-operation: assert RST low between clock edges during the LS·multiply cycle → S=0, Z=1, OVF=0 before the next edge; no RS update at that edge.
